// File: rtl/sump_cmd_ctrl.sv
// SUMP command controller: decodes opcode strobes into capture configuration,
// arm/reset pulses and byte-serial ID/metadata responses. Optional: LOGIP_METADATA_EN.
module sump_cmd_ctrl #(
    parameter int PROBES    = 32,
    parameter int MEM_DEPTH = 4096
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [7:0]        opc_i,
    input  logic [31:0]       cmd_i,
    input  logic              stb_i,
    output logic [PROBES-1:0] trg_mask_o,
    output logic [PROBES-1:0] trg_val_o,
    output logic [31:0]       trg_cfg_o,
    output logic [23:0]       div_o,
    output logic [15:0]       read_cnt_o,
    output logic [15:0]       delay_cnt_o,
    output logic [7:0]        flags_o,
    output logic              arm_o,
    output logic              core_rst_o,
    output logic              xoff_o,
    output logic              busy_o,
    output logic [7:0]        tx_data_o,
    output logic              tx_stb_o,
    input  logic              tx_rdy_i
);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_SEND = 1'b1} state_e;

    localparam logic [7:0]  PROBES_B    = 8'(PROBES);
    localparam logic [31:0] MEM_DEPTH_W = 32'(MEM_DEPTH);

    // Unified response ROM: ID bytes at 0..3, metadata bytes at 4..20.
    function automatic logic [7:0] rom_byte(input logic [4:0] idx);
        logic [7:0] b;
        case (idx)
            5'd0:  b = 8'h31;
            5'd1:  b = 8'h41;
            5'd2:  b = 8'h4C;
            5'd3:  b = 8'h53;
`ifdef LOGIP_METADATA_EN
            5'd4:  b = 8'h01;
            5'd5:  b = 8'h4C;
            5'd6:  b = 8'h6F;
            5'd7:  b = 8'h67;
            5'd8:  b = 8'h49;
            5'd9:  b = 8'h50;
            5'd10: b = 8'h00;
            5'd11: b = 8'h21;
            5'd12: b = MEM_DEPTH_W[31:24];
            5'd13: b = MEM_DEPTH_W[23:16];
            5'd14: b = MEM_DEPTH_W[15:8];
            5'd15: b = MEM_DEPTH_W[7:0];
            5'd16: b = 8'h40;
            5'd17: b = PROBES_B;
            5'd18: b = 8'h41;
            5'd19: b = 8'h02;
            5'd20: b = 8'h00;
`endif
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    state_e            state_q, state_d;
    logic [4:0]        idx_q, idx_d;
    logic              sel_q, sel_d;
    logic [PROBES-1:0] mask_q, mask_d, val_q, val_d;
    logic [31:0]       cfg_q, cfg_d;
    logic [23:0]       div_q, div_d;
    logic [15:0]       rcnt_q, rcnt_d, dcnt_q, dcnt_d;
    logic [7:0]        flags_q, flags_d;
    logic              arm_q, arm_d, crst_q, crst_d, xoff_q, xoff_d;

    logic              rst_cmd_s, start_id_s, start_md_s, hs_s;
    logic [4:0]        last_s;

    assign rst_cmd_s  = stb_i && (opc_i == 8'h00);
    assign start_id_s = stb_i && (opc_i == 8'h02);
`ifdef LOGIP_METADATA_EN
    assign start_md_s = stb_i && (opc_i == 8'h04);
`else
    assign start_md_s = 1'b0;
`endif
    // The handshake is gated by the registered xoff so a paused byte never transfers.
    assign hs_s   = (state_q == ST_SEND) && !xoff_q && tx_rdy_i;
    assign last_s = sel_q ? 5'd20 : 5'd3;

    // Opcode decode into configuration registers and pulses.
    always_comb begin
        mask_d  = mask_q;
        val_d   = val_q;
        cfg_d   = cfg_q;
        div_d   = div_q;
        rcnt_d  = rcnt_q;
        dcnt_d  = dcnt_q;
        flags_d = flags_q;
        xoff_d  = xoff_q;
        arm_d   = 1'b0;
        crst_d  = 1'b0;
        if (stb_i) begin
            case (opc_i)
                8'h00: begin
                    crst_d  = 1'b1;
                    mask_d  = '0;
                    val_d   = '0;
                    cfg_d   = 32'h0;
                    div_d   = 24'h0;
                    rcnt_d  = 16'h0;
                    dcnt_d  = 16'h0;
                    flags_d = 8'h00;
                    xoff_d  = 1'b0;
                end
                8'h01: arm_d   = 1'b1;
                8'h11: xoff_d  = 1'b0;
                8'h13: xoff_d  = 1'b1;
                8'hC0: mask_d  = cmd_i[PROBES-1:0];
                8'hC1: val_d   = cmd_i[PROBES-1:0];
                8'hC2: cfg_d   = cmd_i;
                8'h80: div_d   = cmd_i[23:0];
                8'h81: begin
                    rcnt_d = cmd_i[15:0];
                    dcnt_d = cmd_i[31:16];
                end
                8'h82: flags_d = cmd_i[7:0];
                default: ;
            endcase
        end else begin
            arm_d  = 1'b0;
            crst_d = 1'b0;
        end
    end

    // Response sequencer next-state logic.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        sel_d   = sel_q;
        case (state_q)
            ST_IDLE: begin
                if (start_id_s) begin
                    state_d = ST_SEND;
                    idx_d   = 5'd0;
                    sel_d   = 1'b0;
                end else if (start_md_s) begin
                    state_d = ST_SEND;
                    idx_d   = 5'd4;
                    sel_d   = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (rst_cmd_s || (hs_s && (idx_q == last_s))) begin
                    state_d = ST_IDLE;
                    idx_d   = 5'd0;
                    sel_d   = 1'b0;
                end else if (hs_s) begin
                    idx_d = idx_q + 5'd1;
                end else begin
                    idx_d = idx_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = 5'd0;
                sel_d   = 1'b0;
            end
        endcase
    end

    // Sequencer outputs derived from registered state.
    always_comb begin
        busy_o    = 1'b0;
        tx_stb_o  = 1'b0;
        tx_data_o = 8'h00;
        if (state_q == ST_SEND) begin
            busy_o    = 1'b1;
            tx_stb_o  = !xoff_q;
            tx_data_o = rom_byte(idx_q);
        end else begin
            busy_o = 1'b0;
        end
    end

    // State and configuration registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            idx_q   <= 5'd0;
            sel_q   <= 1'b0;
            mask_q  <= '0;
            val_q   <= '0;
            cfg_q   <= 32'h0;
            div_q   <= 24'h0;
            rcnt_q  <= 16'h0;
            dcnt_q  <= 16'h0;
            flags_q <= 8'h00;
            arm_q   <= 1'b0;
            crst_q  <= 1'b0;
            xoff_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sel_q   <= sel_d;
            mask_q  <= mask_d;
            val_q   <= val_d;
            cfg_q   <= cfg_d;
            div_q   <= div_d;
            rcnt_q  <= rcnt_d;
            dcnt_q  <= dcnt_d;
            flags_q <= flags_d;
            arm_q   <= arm_d;
            crst_q  <= crst_d;
            xoff_q  <= xoff_d;
        end
    end

    assign trg_mask_o  = mask_q;
    assign trg_val_o   = val_q;
    assign trg_cfg_o   = cfg_q;
    assign div_o       = div_q;
    assign read_cnt_o  = rcnt_q;
    assign delay_cnt_o = dcnt_q;
    assign flags_o     = flags_q;
    assign arm_o       = arm_q;
    assign core_rst_o  = crst_q;
    assign xoff_o      = xoff_q;

endmodule

// File: tb/tb_sump_cmd_ctrl.sv
// Randomized bench for sump_cmd_ctrl against a queue-based response model.
module tb_sump_cmd_ctrl;

    localparam int PROBES    = 32;
    localparam int MEM_DEPTH = 4096;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  opc;
    logic [31:0] cmd;
    logic        stb;
    logic        rdy;
    logic [PROBES-1:0] trg_mask, trg_val;
    logic [31:0] trg_cfg;
    logic [23:0] div;
    logic [15:0] read_cnt, delay_cnt;
    logic [7:0]  flags, tx_data;
    logic        arm, core_rst, xoff, busy, tx_stb;

    sump_cmd_ctrl #(.PROBES(PROBES), .MEM_DEPTH(MEM_DEPTH)) dut (
        .clk_i(clk), .rst_i(rst), .opc_i(opc), .cmd_i(cmd), .stb_i(stb),
        .trg_mask_o(trg_mask), .trg_val_o(trg_val), .trg_cfg_o(trg_cfg),
        .div_o(div), .read_cnt_o(read_cnt), .delay_cnt_o(delay_cnt),
        .flags_o(flags), .arm_o(arm), .core_rst_o(core_rst), .xoff_o(xoff),
        .busy_o(busy), .tx_data_o(tx_data), .tx_stb_o(tx_stb), .tx_rdy_i(rdy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: config values plus a queue of bytes still to be sent.
    logic [31:0] m_mask, m_val, m_cfg;
    logic [23:0] m_div;
    logic [15:0] m_rc, m_dc;
    logic [7:0]  m_flags;
    logic        m_arm, m_crst, m_xoff;
    logic [7:0]  m_q[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mask = 0; m_val = 0; m_cfg = 0; m_div = 0; m_rc = 0; m_dc = 0;
        m_flags = 0; m_arm = 0; m_crst = 0; m_xoff = 0;
        m_q.delete();
    endtask

    task automatic model_edge(input bit s, input logic [7:0] o, input logic [31:0] c, input bit r);
        bit was_busy;
        bit hs;
        logic [31:0] md;
        was_busy = (m_q.size() != 0);
        hs = was_busy && !m_xoff && r;
        m_arm = 0;
        m_crst = 0;
        if (s && o == 8'h00) begin
            model_reset();
            m_crst = 1;
        end else begin
            if (hs) void'(m_q.pop_front());
            if (s) begin
                case (o)
                    8'h01: m_arm = 1;
                    8'h02: if (!was_busy) m_q = '{8'h31, 8'h41, 8'h4C, 8'h53};
`ifdef LOGIP_METADATA_EN
                    8'h04: if (!was_busy) begin
                        md = MEM_DEPTH;
                        // 0x01 "LogIP" 0x00, 0x21 depth(MSB first), 0x40 probes, 0x41 0x02, 0x00
                        m_q = '{8'h01, 8'h4C, 8'h6F, 8'h67, 8'h49, 8'h50, 8'h00,
                                8'h21, md[31:24], md[23:16], md[15:8], md[7:0],
                                8'h40, 8'(PROBES), 8'h41, 8'h02, 8'h00};
                    end
`endif
                    8'h11: m_xoff = 0;
                    8'h13: m_xoff = 1;
                    8'hC0: m_mask = c;
                    8'hC1: m_val = c;
                    8'hC2: m_cfg = c;
                    8'h80: m_div = c[23:0];
                    8'h81: begin m_rc = c[15:0]; m_dc = c[31:16]; end
                    8'h82: m_flags = c[7:0];
                    default: ;
                endcase
            end
        end
    endtask

    task automatic check_outputs();
        bit b;
        b = (m_q.size() != 0);
        check_eq("trg_mask", trg_mask, m_mask);
        check_eq("trg_val", trg_val, m_val);
        check_eq("trg_cfg", trg_cfg, m_cfg);
        check_eq("div", {8'h00, div}, {8'h00, m_div});
        check_eq("read_cnt", {16'h0, read_cnt}, {16'h0, m_rc});
        check_eq("delay_cnt", {16'h0, delay_cnt}, {16'h0, m_dc});
        check_eq("flags", {24'h0, flags}, {24'h0, m_flags});
        check_eq("arm", {31'h0, arm}, {31'h0, m_arm});
        check_eq("core_rst", {31'h0, core_rst}, {31'h0, m_crst});
        check_eq("xoff", {31'h0, xoff}, {31'h0, m_xoff});
        check_eq("busy", {31'h0, busy}, {31'h0, b});
        check_eq("tx_stb", {31'h0, tx_stb}, {31'h0, b && !m_xoff});
        if (b) check_eq("tx_data", {24'h0, tx_data}, {24'h0, m_q[0]});
    endtask

    task automatic step(input bit s, input logic [7:0] o, input logic [31:0] c, input bit r);
        stb = s; opc = o; cmd = c; rdy = r;
        @(posedge clk);
        model_edge(s, o, c, r);
        #1;
        check_outputs();
        stb = 1'b0;
    endtask

    task automatic idle(input int n, input bit r);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 32'h0, r);
    endtask

    initial begin
        int r;
        bit s;
        logic [7:0] o;
        rst = 1'b1; stb = 1'b0; opc = 8'h00; cmd = 32'h0; rdy = 1'b0;
        model_reset();
        #12;
        check_outputs();
        rst = 1'b0;
        #1;

        // Directed: mask write, ID with ready high, xoff pause/resume.
        step(1'b1, 8'hC0, 32'h0000_00FF, 1'b0);
        step(1'b1, 8'h02, 32'h0, 1'b1);
        idle(5, 1'b1);
        step(1'b1, 8'h02, 32'h0, 1'b0);
        step(1'b0, 8'h00, 32'h0, 1'b1);
        step(1'b1, 8'h13, 32'h0, 1'b1);
        idle(3, 1'b1);
        step(1'b1, 8'h11, 32'h0, 1'b1);
        idle(4, 1'b1);
        // Counts, arm pulse, abort mid-response, back-to-back strobes.
        step(1'b1, 8'h81, 32'h0010_0020, 1'b0);
        step(1'b1, 8'h01, 32'h0, 1'b0);
        idle(2, 1'b0);
        step(1'b1, 8'h02, 32'h0, 1'b0);
        step(1'b1, 8'h80, 32'h00AB_CDEF, 1'b0);
        step(1'b1, 8'h02, 32'h0, 1'b0);
        step(1'b1, 8'h00, 32'h0, 1'b1);
        idle(2, 1'b1);
        step(1'b1, 8'h04, 32'h0, 1'b1);
        idle(20, 1'b1);

        // Random phase with one asynchronous reset in the middle.
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                rst = 1'b1;
                #2;
                model_reset();
                check_outputs();
                #1;
                rst = 1'b0;
            end
            r = $urandom_range(0, 99);
            s = 1'b1;
            case (1'b1)
                (r < 2):  o = 8'h00;
                (r < 8):  o = 8'h01;
                (r < 18): o = 8'h02;
                (r < 26): o = 8'h04;
                (r < 32): o = 8'h11;
                (r < 36): o = 8'h13;
                (r < 44): o = 8'hC0;
                (r < 50): o = 8'hC1;
                (r < 56): o = 8'hC2;
                (r < 62): o = 8'h80;
                (r < 68): o = 8'h81;
                (r < 74): o = 8'h82;
                (r < 80): o = 8'($urandom);
                default: begin o = 8'h00; s = 1'b0; end
            endcase
            step(s, o, $urandom, ($urandom_range(0, 3) != 0));
        end
        step(1'b1, 8'h11, 32'h0, 1'b1);
        idle(25, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sump_cmd_ctrl.md
Name: sump_cmd_ctrl

Overview:
- Command controller between the Tiny-UART receiver/transmitter pair and the LogIP capture core.
- Consumes decoded SUMP opcode/command strobes and maintains the capture configuration registers.
- Issues arm and core-reset pulses.
- Sequences the multi-byte ID response, and the optional metadata response, onto the UART transmitter through a valid/ready handshake.

Parameters:
- PROBES, 32, number of probe channels; reported in metadata; width of trigger mask/value.
- MEM_DEPTH, 4096, sample memory depth in samples; reported in metadata.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous reset, active-high
- opc_i  in  8  received opcode
- cmd_i  in  32  received command payload; cmd_i[7:0] is the first byte after the opcode
- stb_i  in  1  single-cycle pulse; opc_i and cmd_i are valid in this cycle
- trg_mask_o  out  PROBES  trigger mask, stage 0
- trg_val_o  out  PROBES  trigger value, stage 0
- trg_cfg_o  out  32  trigger configuration, stage 0
- div_o  out  24  sample clock divider
- read_cnt_o  out  16  raw read-count field
- delay_cnt_o  out  16  raw delay-count field
- flags_o  out  8  capture flags
- arm_o  out  1  one-cycle arm pulse
- core_rst_o  out  1  one-cycle core reset pulse
- xoff_o  out  1  transmit pause level
- busy_o  out  1  response sequence in progress
- tx_data_o  out  8  byte to transmitter
- tx_stb_o  out  1  tx_data_o valid
- tx_rdy_i  in  1  transmitter accepts the byte; the transfer occurs when tx_stb_o and tx_rdy_i are both high on a clock edge

Behaviour:
- Reset: all outputs and registers are 0; the FSM is in IDLE. Reset applies asynchronously.
- Decoding happens only when stb_i is high; the result is visible on the next clock edge, so latency is 1 cycle.
- Short opcodes (opc_i[7] = 0) ignore cmd_i:
  - 0x00: core_rst_o pulses; all config registers clear to 0; xoff_o clears; any response in progress aborts, so the FSM goes to IDLE and tx_stb_o is low on the next cycle.
  - 0x01: arm_o pulses high for 1 cycle.
  - 0x02: starts the ID response, bytes 0x31, 0x41, 0x4C, 0x53 ("1ALS").
  - 0x11: xoff_o <= 0.
  - 0x13: xoff_o <= 1.
- Long opcodes:
  - 0xC0: trg_mask_o <= cmd_i[PROBES-1:0].
  - 0xC1: trg_val_o <= cmd_i[PROBES-1:0].
  - 0xC2: trg_cfg_o <= cmd_i.
  - 0x80: div_o <= cmd_i[23:0].
  - 0x81: read_cnt_o <= cmd_i[15:0]; delay_cnt_o <= cmd_i[31:16].
  - 0x82: flags_o <= cmd_i[7:0].
- Any other opcode, including stage 1-3 trigger opcodes, is ignored with no state change.
- FSM states:
  - IDLE: busy_o = 0, tx_stb_o = 0.
  - SEND: busy_o = 1; tx_stb_o = ~xoff_o; tx_data_o = ROM[idx].
  - Transitions:
    - A response opcode in IDLE sets idx to the first byte and enters SEND.
    - In SEND, a handshake increments idx; a handshake on the last byte returns to IDLE.
- Handshake rules:
  - tx_data_o is stable while tx_stb_o is high and not yet accepted.
  - xoff_o = 1 forces tx_stb_o low; no byte transfers, and idx holds.
- Simultaneous events:
  - A response opcode received while in SEND is dropped.
  - Register-write and arm opcodes received while in SEND are accepted normally.
  - 0x00 received in SEND aborts the response, and also clears the registers even if tx_rdy_i is high in the same cycle.
- Back-to-back stb_i on consecutive cycles is supported: each is decoded.

Optional Feature:
- Macro LOGIP_METADATA_EN.
- When defined, opcode 0x04 starts a 17-byte metadata response:
  - 0x01, "LogIP" as 5 bytes, 0x00
  - 0x21, MEM_DEPTH as 4 bytes, MSB first
  - 0x40, PROBES[7:0]
  - 0x41, 0x02
  - 0x00
- The metadata response follows the same SEND rules as the ID response.
- When not defined, 0x04 is ignored and the ROM holds only the ID bytes.

Test Plan:
- Reset, then stb_i with opc 0xC0, cmd 0x0000_00FF -> trg_mask_o = 0xFF one cycle later; all other outputs remain 0.
- opc 0x02 with tx_rdy_i tied high -> tx_data_o = 0x31, 0x41, 0x4C, 0x53 on 4 consecutive cycles; busy_o falls after the 4th.
- opc 0x02, then opc 0x13 after byte 1 is accepted -> tx_stb_o stays low and idx holds; opc 0x11 -> transfer resumes with 0x4C.
- opc 0x81, cmd 0x0010_0020 -> read_cnt_o = 0x0020, delay_cnt_o = 0x0010; then opc 0x01 -> arm_o is high for exactly 1 cycle.
- During ID SEND with tx_rdy_i low, opc 0x00 -> core_rst_o pulses; tx_stb_o is 0 and all config registers are 0 on the next cycle.
- With LOGIP_METADATA_EN defined, opc 0x04 -> 17 bytes in order; bytes 8-11 = 0x00, 0x00, 0x10, 0x00 for MEM_DEPTH = 4096. Without the macro -> no tx_stb_o.
